// File: rtl/stall_flush_sequencer.sv
// Stall/flush sequencer: stretches single-cycle hazard and branch requests into multi-cycle
// pipeline control sequences. Optional performance counters are enabled with STALL_PERF_EN.
module stall_flush_sequencer #(
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic [CNT_W-1:0] stall_cycles,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
`ifdef STALL_PERF_EN
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_flush_cnt,
`endif
  output logic             busy
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_STALL = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [CNT_W-1:0] FLUSH_REM = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] stall_len;
  logic             pc_write_d, ifid_write_d, ifid_flush_d, idex_bubble_d;

  // A requested length of zero behaves as a single-cycle stall.
  assign stall_len = (stall_cycles == '0) ? ONE : stall_cycles;

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    pc_write_d    = 1'b1;
    ifid_write_d  = 1'b1;
    ifid_flush_d  = 1'b0;
    idex_bubble_d = 1'b0;
    case (state_q)
      S_RUN: begin
        if (stall_req) begin
          pc_write_d    = 1'b0;
          ifid_write_d  = 1'b0;
          idex_bubble_d = 1'b1;
          if (stall_len > ONE) begin
            state_d = S_STALL;
            rem_d   = stall_len - ONE;
          end
        end else if (branch_taken) begin
          ifid_flush_d = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            rem_d   = FLUSH_REM;
          end
        end
      end
      S_STALL: begin
        pc_write_d    = 1'b0;
        ifid_write_d  = 1'b0;
        idex_bubble_d = 1'b1;
        // rem==0 here is illegal; treating it like the last cycle returns to RUN.
        if (rem_q <= ONE) begin
          state_d = S_RUN;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - ONE;
        end
      end
      S_FLUSH: begin
        ifid_flush_d = 1'b1;
        if (rem_q <= ONE) begin
          state_d = S_RUN;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - ONE;
        end
      end
      default: begin
        state_d = S_RUN;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Reset forces the safe control pattern combinationally so an abort takes effect at once.
  assign pc_write    = rst ? 1'b0 : pc_write_d;
  assign ifid_write  = rst ? 1'b0 : ifid_write_d;
  assign ifid_flush  = rst ? 1'b1 : ifid_flush_d;
  assign idex_bubble = rst ? 1'b1 : idex_bubble_d;
  assign busy        = !rst && (state_q != S_RUN);

`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (idex_bubble && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
      if (ifid_flush && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_stall_flush_sequencer.sv
// Directed bench for stall_flush_sequencer: one instance with FLUSH_CYCLES=1, one with 2.
// Outputs are packed as {pc_write, ifid_write, ifid_flush, idex_bubble, busy}.
module tb_stall_flush_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall_req = 1'b0;
  logic [1:0] stall_cycles = 2'd0;
  logic       branch_taken = 1'b0;

  logic pc_write_a, ifid_write_a, ifid_flush_a, idex_bubble_a, busy_a;
  logic pc_write_b, ifid_write_b, ifid_flush_b, idex_bubble_b, busy_b;
`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_a, perf_flush_a, perf_stall_b, perf_flush_b;
`endif

  int checks_total = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  stall_flush_sequencer #(.CNT_W(2), .FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .stall_req(stall_req), .stall_cycles(stall_cycles),
    .branch_taken(branch_taken), .pc_write(pc_write_a), .ifid_write(ifid_write_a),
    .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a),
`ifdef STALL_PERF_EN
    .perf_stall_cnt(perf_stall_a), .perf_flush_cnt(perf_flush_a),
`endif
    .busy(busy_a)
  );

  stall_flush_sequencer #(.CNT_W(2), .FLUSH_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .stall_req(stall_req), .stall_cycles(stall_cycles),
    .branch_taken(branch_taken), .pc_write(pc_write_b), .ifid_write(ifid_write_b),
    .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b),
`ifdef STALL_PERF_EN
    .perf_stall_cnt(perf_stall_b), .perf_flush_cnt(perf_flush_b),
`endif
    .busy(busy_b)
  );

  wire [4:0] outs_a = {pc_write_a, ifid_write_a, ifid_flush_a, idex_bubble_a, busy_a};
  wire [4:0] outs_b = {pc_write_b, ifid_write_b, ifid_flush_b, idex_bubble_b, busy_b};

  localparam logic [4:0] O_RESET = 5'b00110;
  localparam logic [4:0] O_RUN   = 5'b11000;
  localparam logic [4:0] O_STALL = 5'b00010;
  localparam logic [4:0] O_STALB = 5'b00011;
  localparam logic [4:0] O_FLUSH = 5'b11100;
  localparam logic [4:0] O_FLUSB = 5'b11101;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle's inputs just after the falling edge, then sample the Mealy outputs.
  task automatic cyc(input string tag, input logic r, input logic sr, input logic [1:0] sc,
                     input logic bt, input logic [4:0] exp_a);
    @(negedge clk);
    rst = r; stall_req = sr; stall_cycles = sc; branch_taken = bt;
    #1;
    check_val(tag, {27'd0, outs_a}, {27'd0, exp_a});
    $display("cycle %s rst=%0b req=%0b len=%0d br=%0b outs_a=%05b outs_b=%05b",
             tag, r, sr, sc, bt, outs_a, outs_b);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc("reset", 1'b1, 1'b0, 2'd0, 1'b0, O_RESET);
    check_val("reset_b", {27'd0, outs_b}, {27'd0, O_RESET});
    cyc("release", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);
    cyc("idle", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);

    cyc("stall1", 1'b0, 1'b1, 2'd1, 1'b0, O_STALL);
    cyc("stall1_after", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);
`ifdef STALL_PERF_EN
    check_val("perf_stall_one", perf_stall_a, 32'd1);
`endif

    cyc("stall2_c0", 1'b0, 1'b1, 2'd2, 1'b0, O_STALL);
    cyc("stall2_c1", 1'b0, 1'b0, 2'd0, 1'b0, O_STALB);
    cyc("stall2_after", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);

    cyc("stall0", 1'b0, 1'b1, 2'd0, 1'b0, O_STALL);
    cyc("stall0_after", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);

    // Requests arriving during STALL are ignored, including a branch.
    cyc("stall3_c0", 1'b0, 1'b1, 2'd3, 1'b0, O_STALL);
    cyc("stall3_c1", 1'b0, 1'b1, 2'd1, 1'b1, O_STALB);
    cyc("stall3_c2", 1'b0, 1'b0, 2'd0, 1'b1, O_STALB);
    cyc("stall3_after", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);

    cyc("b2b_c0", 1'b0, 1'b1, 2'd2, 1'b0, O_STALL);
    cyc("b2b_c1", 1'b0, 1'b0, 2'd0, 1'b0, O_STALB);
    cyc("b2b_again", 1'b0, 1'b1, 2'd1, 1'b0, O_STALL);
    cyc("b2b_after", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);

    cyc("prio_stall", 1'b0, 1'b1, 2'd1, 1'b1, O_STALL);
    cyc("branch_only", 1'b0, 1'b0, 2'd0, 1'b1, O_FLUSH);
    cyc("branch_after", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);
    check_val("b_flush_tail", {27'd0, outs_b}, {27'd0, O_FLUSB});
    for (int i = 0; i < 3; i++) cyc("settle", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);
    check_val("b_settled", {27'd0, outs_b}, {27'd0, O_RUN});

    cyc("flush2_c0", 1'b0, 1'b0, 2'd0, 1'b1, O_FLUSH);
    check_val("b_flush_c0", {27'd0, outs_b}, {27'd0, O_FLUSH});
    cyc("flush2_c1", 1'b0, 1'b1, 2'd1, 1'b0, O_STALL);
    check_val("b_flush_c1", {27'd0, outs_b}, {27'd0, O_FLUSB});
    cyc("flush2_after", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);
    check_val("b_flush_after", {27'd0, outs_b}, {27'd0, O_RUN});

    cyc("abort_c0", 1'b0, 1'b1, 2'd3, 1'b0, O_STALL);
    cyc("abort_rst", 1'b1, 1'b0, 2'd0, 1'b0, O_RESET);
`ifdef STALL_PERF_EN
    check_val("perf_stall_rst", perf_stall_a, 32'd0);
    check_val("perf_flush_rst", perf_flush_a, 32'd0);
`endif
    cyc("abort_rst2", 1'b1, 1'b0, 2'd0, 1'b0, O_RESET);
    cyc("abort_release", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);
    cyc("abort_idle", 1'b0, 1'b0, 2'd0, 1'b0, O_RUN);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
